// File: rtl/fifo_mem_2p.sv
// Two-port register array: synchronous write, asynchronous read, no reset.
// Contents are undefined until written. The owner of the pointers masks reads of unwritten entries.
module fifo_mem_2p #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Write port: store wdata at waddr on the rising edge when enabled
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

// File: rtl/mix_out_buffer.sv
// Elastic FWFT buffer behind mix: captures valid samples and drains them through valid/ready.
// When the buffer is full, incoming samples are dropped. A sticky flag and a saturating counter record each drop.
module mix_out_buffer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        in_valid,
    input  logic [WIDTH-1:0]            in_data,
    output logic                        in_ready,
    output logic                        out_valid,
    output logic [WIDTH-1:0]            out_data,
    input  logic                        out_ready,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        full,
    output logic                        empty,
    output logic                        overflow,
    output logic [7:0]                  drop_cnt,
    input  logic                        clr_ovf
);

    localparam int ADDR_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_full;
    logic              r_empty;
    logic              r_overflow;
    logic [7:0]        r_drop_cnt;

    logic              w_push;
    logic              w_pop;
    logic              w_drop;
    logic              w_we;
    logic [ADDR_W:0]   w_count_nxt;
    logic [WIDTH-1:0]  w_rdata;

    // A full buffer refuses input even when a pop happens in the same cycle, so there is no same-cycle refill.
    assign w_push = in_valid & ~r_full;
    assign w_pop  = ~r_empty & out_ready;
    // A sample discarded by flush is not counted as a drop.
    assign w_drop = in_valid & r_full & ~flush;
    assign w_we   = w_push & ~flush;

    fifo_mem_2p #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (w_we),
        .waddr (r_wr_ptr),
        .wdata (in_data),
        .raddr (r_rd_ptr),
        .rdata (w_rdata)
    );

    // Next occupancy: flush clears it; a simultaneous push and pop leaves it unchanged
    always_comb begin
        w_count_nxt = r_count;
        if (flush) begin
            w_count_nxt = {(ADDR_W+1){1'b0}};
        end else if (w_push && !w_pop) begin
            w_count_nxt = r_count + (ADDR_W+1)'(1);
        end else if (w_pop && !w_push) begin
            w_count_nxt = r_count - (ADDR_W+1)'(1);
        end else begin
            w_count_nxt = r_count;
        end
    end

    // Pointers, occupancy and the registered full/empty flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= {ADDR_W{1'b0}};
            r_rd_ptr <= {ADDR_W{1'b0}};
            r_count  <= {(ADDR_W+1){1'b0}};
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (flush) begin
                r_wr_ptr <= {ADDR_W{1'b0}};
                r_rd_ptr <= {ADDR_W{1'b0}};
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
                end
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == (ADDR_W+1)'(DEPTH));
            r_empty <= (w_count_nxt == {(ADDR_W+1){1'b0}});
        end
    end

    // Drop bookkeeping: if a drop and a clear happen in the same cycle, the drop wins and the count restarts at 1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= 8'd0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (clr_ovf) begin
                r_drop_cnt <= 8'd1;
            end else if (r_drop_cnt != 8'hFF) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end else if (clr_ovf) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= 8'd0;
        end
    end

    assign in_ready  = ~r_full;
    assign out_valid = ~r_empty;
    // Force the head to zero while empty, so stale memory never appears on the output.
    assign out_data  = r_empty ? {WIDTH{1'b0}} : w_rdata;
    assign count     = r_count;
    assign full      = r_full;
    assign empty     = r_empty;
    assign overflow  = r_overflow;
    assign drop_cnt  = r_drop_cnt;

endmodule
